dense_fc_ram_reader: RTL and testbench

Read-side sequencer for the dense/FC weight and activation RAM. On a start pulse it issues a run of consecutive single-port reads (`base_addr`, `base_addr+1`, …, wrapping modulo DEPTH) against the RAM's registered 1-cycle read port. It returns the bytes in order on a valid/ready stream with backpressure. It sits between the FC RAM and the dense-layer MAC datapath and never writes the RAM.

---
 rtl/dense_fc_pkg.sv | 22 ++
 rtl/dense_fc_stream_fifo.sv | 66 ++++++
 rtl/dense_fc_ram_reader.sv | 187 ++++++++++++++++++
 tb/tb_dense_fc_ram_reader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dense_fc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dense_fc_pkg
// Description : Shared types and constants for the dense/FC RAM read path.
//               reader_state_e    - read sequencer FSM states
//               READER_FIFO_DEPTH - return-path FIFO depth (also credit limit)
//               STALL_CNT_W       - width of the optional stall counter
// Revision    : 1.0 - initial release
// ============================================================================
package dense_fc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } reader_state_e;

  localparam int READER_FIFO_DEPTH = 4;
  localparam int STALL_CNT_W       = 16;

endpackage
`default_nettype wire

// File: rtl/dense_fc_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dense_fc_stream_fifo
// Description : Small register FIFO holding returned RAM words plus their
//               last-word flag. Head entry is presented directly so the
//               stream outputs come straight from storage registers.
// Ports       : clk, rst_n        - clock, asynchronous active-low reset
//               i_push/i_push_data - write a word at the tail
//               i_pop             - remove the head word
//               o_head            - head word (held while not popped)
//               o_count/o_empty   - occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module dense_fc_stream_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty
);

  // Pointers wrap naturally, so DEPTH is expected to be a power of two.
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && (r_count != CNT_W'(DEPTH));
  assign w_pop   = i_pop && (r_count != '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dense_fc_ram_reader.sv
`default_nettype none
// ============================================================================
// Module      : dense_fc_ram_reader
// Description : Read-side sequencer for the dense/FC RAM. A start pulse
//               launches a run of consecutive reads (wrapping modulo DEPTH)
//               against a 1-cycle registered read port; returned words are
//               streamed out in order on a valid/ready interface.
// Ports       : clk, reset (async active-low)
//               start/base_addr/length - run request (accepted when idle)
//               busy/done              - run status
//               ram_*                  - RAM read port (never writes)
//               out_data/out_valid/out_ready/out_last - output stream
//               stall_count            - only with DENSE_FC_RAM_READER_STATS_EN
// Config      : `define DENSE_FC_RAM_READER_STATS_EN to add the saturating
//               stall counter port.
// Revision    : 1.0 - initial release
// ============================================================================
module dense_fc_ram_reader
  import dense_fc_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int LEN_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    ram_addr,
  output logic             ram_read_enable,
  output logic             ram_write_enable,
  input  logic [WIDTH-1:0] ram_data_out,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
`ifdef DENSE_FC_RAM_READER_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_count
`endif
);

  localparam int CNT_W = $clog2(READER_FIFO_DEPTH + 1);

  reader_state_e    r_state;
  logic [AW-1:0]    r_ptr;
  logic [AW-1:0]    r_ram_addr;
  logic [LEN_W-1:0] r_issue_rem;
  logic [LEN_W-1:0] r_out_rem;
  logic             r_rd_en;
  logic             r_rd_last;
  logic             r_ret_vld;
  logic             r_ret_last;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W-1:0] w_fifo_count;
  logic             w_fifo_empty;
  logic [WIDTH:0]   w_head;
  logic             w_hs;
  logic [CNT_W:0]   w_occupancy;
  logic             w_credit_ok;

  function automatic logic [AW-1:0] f_next_addr(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
  endfunction

  // Reads in flight are the one returning this cycle (r_ret_vld) and the one
  // being issued this cycle (r_rd_en). A new read is scheduled for next cycle
  // only if, ignoring any pops, the FIFO could still absorb it.
  assign w_occupancy = {1'b0, w_fifo_count} + (CNT_W + 1)'(r_ret_vld)
                     + (CNT_W + 1)'(r_rd_en);
  assign w_credit_ok = (w_occupancy < (CNT_W + 1)'(READER_FIFO_DEPTH));
  assign w_hs        = !w_fifo_empty && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_ram_addr  <= '0;
      r_issue_rem <= '0;
      r_out_rem   <= '0;
      r_rd_en     <= 1'b0;
      r_rd_last   <= 1'b0;
      r_ret_vld   <= 1'b0;
      r_ret_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_ret_vld  <= r_rd_en;
      r_ret_last <= r_rd_last;
      if (w_hs) r_out_rem <= r_out_rem - LEN_W'(1);
      case (r_state)
        IDLE: begin
          r_rd_en   <= 1'b0;
          r_rd_last <= 1'b0;
          if (start) begin
            if (length == '0) begin
              r_done <= 1'b1;
            end else begin
              // First read is scheduled straight from the request.
              r_state     <= (length == LEN_W'(1)) ? DRAIN : ISSUE;
              r_busy      <= 1'b1;
              r_rd_en     <= 1'b1;
              r_rd_last   <= (length == LEN_W'(1));
              r_ram_addr  <= base_addr;
              r_ptr       <= f_next_addr(base_addr);
              r_issue_rem <= length - LEN_W'(1);
              r_out_rem   <= length;
            end
          end
        end
        ISSUE: begin
          // r_issue_rem is never zero here: the final issue moves to DRAIN.
          if (w_credit_ok) begin
            r_rd_en     <= 1'b1;
            r_rd_last   <= (r_issue_rem == LEN_W'(1));
            r_ram_addr  <= r_ptr;
            r_ptr       <= f_next_addr(r_ptr);
            r_issue_rem <= r_issue_rem - LEN_W'(1);
            if (r_issue_rem == LEN_W'(1)) r_state <= DRAIN;
          end else begin
            r_rd_en   <= 1'b0;
            r_rd_last <= 1'b0;
          end
        end
        DRAIN: begin
          r_rd_en   <= 1'b0;
          r_rd_last <= 1'b0;
          if (w_hs && (r_out_rem == LEN_W'(1))) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  dense_fc_stream_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (READER_FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .i_push      (r_ret_vld),
    .i_push_data ({r_ret_last, ram_data_out}),
    .i_pop       (w_hs),
    .o_head      (w_head),
    .o_count     (w_fifo_count),
    .o_empty     (w_fifo_empty)
  );

  assign busy             = r_busy;
  assign done             = r_done;
  assign ram_addr         = r_ram_addr;
  assign ram_read_enable  = r_rd_en;
  assign ram_write_enable = 1'b0;
  assign out_valid        = !w_fifo_empty;
  assign out_data         = w_head[WIDTH-1:0];
  assign out_last         = w_head[WIDTH];

`ifdef DENSE_FC_RAM_READER_STATS_EN
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_stall_cnt <= '0;
    end else if (!w_fifo_empty && !out_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign stall_count = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dense_fc_ram_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dense_fc_ram_reader
// Description : Self-checking bench for dense_fc_ram_reader. A RAM model
//               with a registered read port answers the DUT; each run pushes
//               its expected addresses and words into queues, and a monitor
//               compares them against what the DUT presents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dense_fc_ram_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] base_addr;
  logic [8:0] length;
  logic       busy;
  logic       done;
  logic [7:0] ram_addr;
  logic       ram_read_enable;
  logic       ram_write_enable;
  logic [7:0] ram_q;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
`ifdef DENSE_FC_RAM_READER_STATS_EN
  logic [15:0] stall_count;
`endif

  dense_fc_ram_reader #(
    .DEPTH (256),
    .WIDTH (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .base_addr        (base_addr),
    .length           (length),
    .busy             (busy),
    .done             (done),
    .ram_addr         (ram_addr),
    .ram_read_enable  (ram_read_enable),
    .ram_write_enable (ram_write_enable),
    .ram_data_out     (ram_q),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_last         (out_last)
`ifdef DENSE_FC_RAM_READER_STATS_EN
    ,
    .stall_count      (stall_count)
`endif
  );

  always #5 clk = ~clk;

  // RAM model: registered 1-cycle read port.
  logic [7:0] mem [256];
  always @(posedge clk) if (ram_read_enable) ram_q <= mem[ram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] exp_q[$];   // {last, data}
  logic [7:0] addr_q[$];
  int t0 = 0;
  int done_rel = -1;
  int first_valid_rel = -1;
  bit busy_seen = 0;
  bit rden_seen = 0;
  int outstanding = 0;
  int stall_model = 0;
  int m_rel;

  task automatic chk(input string name, input longint act, input longint expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, expv, expv, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      addr_q.delete();
      outstanding = 0;
    end else begin
      m_rel = cyc - t0;
      chk("ram_write_enable", ram_write_enable, 0);
      if (busy) busy_seen = 1;
      if (ram_read_enable) begin
        rden_seen = 1;
        outstanding++;
        chk("outstanding_le_4", (outstanding <= 4), 1);
        if (addr_q.size() == 0) fail_now("unexpected_read");
        else chk("ram_addr", ram_addr, addr_q.pop_front());
      end
      if (out_valid) begin
        if (first_valid_rel < 0) first_valid_rel = m_rel;
        if (exp_q.size() == 0) begin
          fail_now("unexpected_word");
        end else begin
          chk("out_data", out_data, exp_q[0][7:0]);
          chk("out_last", out_last, exp_q[0][8]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            outstanding--;
          end
        end
        if (!out_ready && stall_model < 16'hFFFF) stall_model++;
      end
      if (done) begin
        if (done_rel < 0) done_rel = m_rel;
        chk("busy_at_done", busy, 0);
`ifdef DENSE_FC_RAM_READER_STATS_EN
        chk("stall_count_at_done", stall_count, stall_model);
`endif
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ram_re"}, ram_read_enable, 0);
    chk({tag, "_ram_we"}, ram_write_enable, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_data"}, out_data, 0);
`ifdef DENSE_FC_RAM_READER_STATS_EN
    chk({tag, "_stall_count"}, stall_count, 0);
`endif
  endtask

  // Issue a start in the current cycle (cycle 0 of the run).
  task automatic kick(input int base, input int len);
    @(posedge clk); #1;
    done_rel = -1;
    first_valid_rel = -1;
    busy_seen = 0;
    rden_seen = 0;
    stall_model = 0;
    for (int i = 0; i < len; i++) begin
      int a;
      a = (base + i) % 256;
      addr_q.push_back(8'(a));
      exp_q.push_back({(i == len - 1), mem[a]});
    end
    t0 = cyc;
    start = 1'b1;
    base_addr = 8'(base);
    length = 9'(len);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: ready high; 1: ready low in cycles 4..9; 2: random ready.
  task automatic wait_done(input int mode, input int ign_rel, input int ign_base, input int ign_len);
    int rel;
    while (done_rel < 0 && (cyc - t0) < 3000) begin
      rel = cyc - t0;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(rel >= 4 && rel <= 9);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (rel == ign_rel) begin
        start = 1'b1;
        base_addr = 8'(ign_base);
        length = 9'(ign_len);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (done_rel < 0) fail_now("done_timeout");
    chk("exp_q_drained", exp_q.size(), 0);
    chk("addr_q_drained", addr_q.size(), 0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Basic run: data in cycles 3..6, done in cycle 7.
    kick(8'h10, 4);
    wait_done(0, -1, 0, 0);
    chk("basic_first_valid", first_valid_rel, 3);
    chk("basic_done_cycle", done_rel, 7);

    // Address wrap.
    kick(8'hFE, 4);
    wait_done(0, -1, 0, 0);
    chk("wrap_done_cycle", done_rel, 7);

    // Backpressure in cycles 4..9.
    kick(8'h00, 16);
    wait_done(1, -1, 0, 0);
`ifdef DENSE_FC_RAM_READER_STATS_EN
    chk("bp_stall_count", stall_count, 6);
`endif

    // Zero-length run.
    kick(8'h55, 0);
    wait_done(0, -1, 0, 0);
    chk("len0_done_cycle", done_rel, 1);
    chk("len0_no_reads", rden_seen, 0);
    chk("len0_no_busy", busy_seen, 0);

    // Start while busy is ignored.
    kick(8'h40, 8);
    wait_done(0, 3, 8'h80, 3);
    chk("ignored_start_done_cycle", done_rel, 11);

    // Reset in cycle 5 of a 16-word run, then a fresh run.
    kick(8'h20, 16);
    while ((cyc - t0) < 5) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("midrun_reset");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    kick(8'h30, 5);
    wait_done(0, -1, 0, 0);
    chk("post_reset_first_valid", first_valid_rel, 3);
    chk("post_reset_done_cycle", done_rel, 8);

    // Randomized runs over random RAM contents.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int r = 0; r < 24; r++) begin
      int b;
      int l;
      int m;
      b = $urandom_range(0, 255);
      l = (r == 5) ? 256 : $urandom_range(0, 40);
      m = (r % 3 == 0) ? 0 : 2;
      kick(b, l);
      wait_done(m, -1, 0, 0);
      if (m == 0) chk("rand_done_cycle", done_rel, (l == 0) ? 1 : l + 3);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
